// File: rtl/ip_seq_pkg.sv
// Shared operation encodings for the instruction-pointer sequencer and its decoder.
package ip_seq_pkg;

  typedef enum logic [2:0] {
    IP_HOLD   = 3'b000,
    IP_INC    = 3'b001,
    IP_LOAD   = 3'b010,
    IP_BRANCH = 3'b011,
    IP_CALL   = 3'b100,
    IP_RET    = 3'b101
  } ip_op_e;

endpackage

// File: rtl/ip_ret_stack.sv
// Return-address LIFO: shift-register stack, top entry always at mem[0], writes visible next cycle.
// Full pushes and empty pops are dropped; occupancy flags decode straight from the level register.
module ip_ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic [W-1:0]               DIN,
  output logic [W-1:0]               TOP,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] lvl;
  logic          do_push;
  logic          do_pop;

  assign do_push = PUSH && !FULL;
  assign do_pop  = POP && !EMPTY;

  // Shifting keeps the top at a fixed slot, so no level-indexed read mux is needed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      lvl <= '0;
    end else if (do_push) begin
      mem[0] <= DIN;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      lvl <= lvl + 1'b1;
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
      lvl <= lvl - 1'b1;
    end
  end

  assign LEVEL = lvl;
  assign FULL  = (lvl == LW'(DEPTH));
  assign EMPTY = (lvl == '0);
  assign TOP   = EMPTY ? '0 : mem[0];

endmodule

// File: rtl/ip_seq_unit.sv
// Instruction-pointer sequencer (INC/LOAD/BRANCH/CALL/RET), 1-cycle OP->Q; ENA=0 freezes all state.
// IP_TRAP_EN: stack overflow/underflow redirects Q to TRAP_VEC instead of D / Q+STEP.
module ip_seq_unit
  import ip_seq_pkg::*;
#(
  parameter int          W        = 16,
  parameter int          STEP     = 1,
  parameter int          DEPTH    = 8,
  parameter logic [63:0] RST_VEC  = 64'h0,
  parameter logic [63:0] TRAP_VEC = 64'hFFF0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENA,
  input  logic [2:0]                 OP,
  input  logic [W-1:0]               D,
  output logic [W-1:0]               Q,
  output logic [W-1:0]               RA,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ERR
);

  logic [W-1:0] q_inc;
  logic [W-1:0] q_nxt;
  logic         err_nxt;
  logic         push;
  logic         pop;

  assign q_inc = Q + W'(STEP);

  ip_ret_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (push),
    .POP   (pop),
    .DIN   (q_inc),
    .TOP   (RA),
    .LEVEL (LEVEL),
    .FULL  (FULL),
    .EMPTY (EMPTY)
  );

  always_comb begin
    q_nxt   = Q;
    err_nxt = ERR;
    push    = 1'b0;
    pop     = 1'b0;
    if (ENA) begin
      case (OP)
        IP_INC:    q_nxt = q_inc;
        IP_LOAD:   q_nxt = D;
        IP_BRANCH: q_nxt = Q + D;
        IP_CALL: begin
          if (FULL) begin
            err_nxt = 1'b1;
`ifdef IP_TRAP_EN
            q_nxt   = W'(TRAP_VEC);
`else
            q_nxt   = D;
`endif
          end else begin
            push  = 1'b1;
            q_nxt = D;
          end
        end
        IP_RET: begin
          if (EMPTY) begin
            err_nxt = 1'b1;
`ifdef IP_TRAP_EN
            q_nxt   = W'(TRAP_VEC);
`else
            q_nxt   = q_inc;
`endif
          end else begin
            pop   = 1'b1;
            q_nxt = RA;
          end
        end
        default: q_nxt = Q;  // HOLD and reserved codes
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q   <= W'(RST_VEC);
      ERR <= 1'b0;
    end else begin
      Q   <= q_nxt;
      ERR <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ip_seq_unit.sv
// Scoreboard bench for ip_seq_unit at default parameters (W=16, STEP=1, DEPTH=8), both IP_TRAP_EN builds.
module tb_ip_seq_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENA = 1'b0;
  logic [2:0]  OP  = 3'b000;
  logic [15:0] D   = 16'h0000;
  logic [15:0] Q;
  logic [15:0] RA;
  logic [3:0]  LEVEL;
  logic        FULL;
  logic        EMPTY;
  logic        ERR;

  ip_seq_unit dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .OP(OP), .D(D),
    .Q(Q), .RA(RA), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

`ifdef IP_TRAP_EN
  localparam logic [15:0] UF_Q0   = 16'hFFF0;  // underflow RET from Q=0
  localparam logic [15:0] UF_PUSH = 16'hFFF1;
  localparam logic [15:0] OVF_Q   = 16'hFFF0;
  localparam logic [15:0] UF_Q20  = 16'hFFF0;  // underflow RET from Q=0x0020
  localparam logic [15:0] UF_INC  = 16'hFFF1;
`else
  localparam logic [15:0] UF_Q0   = 16'h0001;
  localparam logic [15:0] UF_PUSH = 16'h0002;
  localparam logic [15:0] OVF_Q   = 16'h0500;
  localparam logic [15:0] UF_Q20  = 16'h0021;
  localparam logic [15:0] UF_INC  = 16'h0022;
`endif

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] ra;
    logic [3:0]  level;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event mon_tick;

  // Sample one time unit after each rising edge.
  always @(posedge CLK) begin
    #1;
    ->mon_tick;
  end

  initial begin
    forever begin
      @(mon_tick);
      if (exp_q.size() > 0) begin
        exp_t x;
        logic xf, xe;
        x  = exp_q.pop_front();
        xf = (x.level == 4'd8);
        xe = (x.level == 4'd0);
        n_chk++;
        if ({Q, RA, LEVEL, FULL, EMPTY, ERR} !== {x.q, x.ra, x.level, xf, xe, x.err}) begin
          n_fail++;
          $display("FAIL %s: got Q=%h RA=%h LEVEL=%0d FULL=%b EMPTY=%b ERR=%b, want Q=%h RA=%h LEVEL=%0d FULL=%b EMPTY=%b ERR=%b",
                   x.name, Q, RA, LEVEL, FULL, EMPTY, ERR, x.q, x.ra, x.level, xf, xe, x.err);
        end
      end
    end
  end

  initial begin
    repeat (2000) @(posedge CLK);
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: test did not finish within 2000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic expect_state(input string nm, input logic [15:0] eq, input logic [15:0] era,
                              input logic [3:0] elv, input logic eerr);
    exp_t x;
    x.name = nm; x.q = eq; x.ra = era; x.level = elv; x.err = eerr;
    exp_q.push_back(x);
  endtask

  task automatic step(input string nm, input logic e, input logic [2:0] o, input logic [15:0] dd,
                      input logic [15:0] eq, input logic [15:0] era, input logic [3:0] elv,
                      input logic eerr);
    @(negedge CLK);
    ENA = e; OP = o; D = dd;
    expect_state(nm, eq, era, elv, eerr);
  endtask

  // Asserted between clock edges; outputs must clear without waiting for CLK.
  task automatic async_rst(input string nm);
    @(negedge CLK);
    #2;
    ENA = 1'b0;
    RST = 1'b1;
    #1;
    expect_state(nm, 16'h0000, 16'h0000, 4'd0, 1'b0);
    ->mon_tick;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #3;
    n_chk++;
    if ({Q, RA, LEVEL, FULL, EMPTY, ERR} !== {16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state_direct: got Q=%h RA=%h LEVEL=%0d FULL=%b EMPTY=%b ERR=%b",
               Q, RA, LEVEL, FULL, EMPTY, ERR);
    end
    expect_state("reset_state", 16'h0000, 16'h0000, 4'd0, 1'b0);
    ->mon_tick;
    @(negedge CLK);
    RST = 1'b0;

    // Build Q=0x0042, LEVEL=3, ERR=1 then reset mid-run
    step("ret_underflow_q0", 1'b1, 3'b101, 16'h0000, UF_Q0,    16'h0000, 4'd0, 1'b1);
    step("call_1",           1'b1, 3'b100, 16'h0010, 16'h0010, UF_PUSH,  4'd1, 1'b1);
    step("call_2",           1'b1, 3'b100, 16'h0020, 16'h0020, 16'h0011, 4'd2, 1'b1);
    step("call_3",           1'b1, 3'b100, 16'h0030, 16'h0030, 16'h0021, 4'd3, 1'b1);
    step("load_42",          1'b1, 3'b010, 16'h0042, 16'h0042, 16'h0021, 4'd3, 1'b1);
    step("ena_low_hold",     1'b0, 3'b001, 16'h0000, 16'h0042, 16'h0021, 4'd3, 1'b1);
    async_rst("reset_mid_run");

    step("load_ffff",        1'b1, 3'b010, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd0, 1'b0);
    step("inc_wrap",         1'b1, 3'b001, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0);
    step("inc_ena_low",      1'b0, 3'b001, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0);
    step("load_0010",        1'b1, 3'b010, 16'h0010, 16'h0010, 16'h0000, 4'd0, 1'b0);
    step("branch_back",      1'b1, 3'b011, 16'hFFF8, 16'h0008, 16'h0000, 4'd0, 1'b0);
    step("load_fffe",        1'b1, 3'b010, 16'hFFFE, 16'hFFFE, 16'h0000, 4'd0, 1'b0);
    step("branch_wrap",      1'b1, 3'b011, 16'h0004, 16'h0002, 16'h0000, 4'd0, 1'b0);

    step("load_0100",        1'b1, 3'b010, 16'h0100, 16'h0100, 16'h0000, 4'd0, 1'b0);
    step("nest_call_a",      1'b1, 3'b100, 16'h0200, 16'h0200, 16'h0101, 4'd1, 1'b0);
    step("nest_call_b",      1'b1, 3'b100, 16'h0300, 16'h0300, 16'h0201, 4'd2, 1'b0);
    step("nest_ret_b",       1'b1, 3'b101, 16'h0000, 16'h0201, 16'h0101, 4'd1, 1'b0);
    step("nest_ret_a",       1'b1, 3'b101, 16'h0000, 16'h0101, 16'h0000, 4'd0, 1'b0);

    // Fill the stack: first push is 0x0101+1, later pushes are previous target+1
    for (int i = 0; i < 8; i++) begin
      logic [15:0] tgt;
      logic [15:0] top;
      tgt = 16'h1000 + 16'(i);
      top = (i == 0) ? 16'h0102 : tgt;
      step("fill_call", 1'b1, 3'b100, tgt, tgt, top, 4'(i + 1), 1'b0);
    end
    step("call_overflow",    1'b1, 3'b100, 16'h0500, OVF_Q,    16'h1007, 4'd8, 1'b1);
    step("ret_after_full",   1'b1, 3'b101, 16'h0000, 16'h1007, 16'h1006, 4'd7, 1'b1);
    async_rst("reset_after_ovf");

    step("load_0020",        1'b1, 3'b010, 16'h0020, 16'h0020, 16'h0000, 4'd0, 1'b0);
    step("ret_underflow",    1'b1, 3'b101, 16'h0000, UF_Q20,   16'h0000, 4'd0, 1'b1);
    step("op110_hold",       1'b1, 3'b110, 16'h1234, UF_Q20,   16'h0000, 4'd0, 1'b1);
    step("op111_hold",       1'b1, 3'b111, 16'h5678, UF_Q20,   16'h0000, 4'd0, 1'b1);
    step("inc_err_sticky",   1'b1, 3'b001, 16'h0000, UF_INC,   16'h0000, 4'd0, 1'b1);

    @(negedge CLK);
    ENA = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations never checked", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
